// File: rtl/coin_collector.sv
// Credit front end of the vending datapath: accumulates coins, waits for a
// covered selection, then hands credit and product code off via done/vend_ready.
module coin_collector #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_coin_in,
  input  logic [1:0] i_coin_val,
  input  logic       i_sel_valid,
  input  logic [1:0] i_sel,
  input  logic       i_cancel,
  input  logic       i_vend_ready,
  output logic [4:0] o_money,
  output logic [1:0] o_product,
  output logic       o_done,
  output logic       o_refund,
  output logic [4:0] o_refund_amt,
  output logic       o_coin_reject
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REQUEST = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  localparam logic [7:0] L_IDLE_LAST = 8'(TIMEOUT - 1);

  state_t     r_state,      w_state_n;
  logic [4:0] r_credit,     w_credit_n;
  logic [1:0] r_prod,       w_prod_n;
  logic       r_sel_seen,   w_sel_seen_n;
  logic [7:0] r_idle_cnt,   w_idle_cnt_n;
  logic       r_coin_reject, w_reject;

  logic [4:0] w_coin_amt;
  logic [5:0] w_sum;
  logic       w_ovf;
  logic [4:0] w_price;
  logic       w_coin_ok;
  logic       w_activity;

  always_comb begin
    case (i_coin_val)
      2'b00:   w_coin_amt = 5'd1;
      2'b01:   w_coin_amt = 5'd2;
      2'b10:   w_coin_amt = 5'd5;
      default: w_coin_amt = 5'd10;
    endcase
    case (r_prod)
      2'b00:   w_price = 5'd5;
      2'b01:   w_price = 5'd10;
      2'b10:   w_price = 5'd15;
      default: w_price = 5'd20;
    endcase
  end

  // Sum at 6 bits so a carry out of the credit register marks overflow.
  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_amt};
  assign w_ovf = w_sum[5];

  // A coin racing a cancel is refused so the refund is the pre-coin credit.
  assign w_coin_ok  = i_coin_in && !i_cancel && !w_ovf;
  assign w_activity = w_coin_ok || i_sel_valid;

  always_comb begin
    w_state_n    = r_state;
    w_credit_n   = r_credit;
    w_prod_n     = r_prod;
    w_sel_seen_n = r_sel_seen;
    w_idle_cnt_n = r_idle_cnt;
    w_reject     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_coin_in || i_sel_valid) begin
          if (i_coin_in) w_credit_n = w_sum[4:0];
          if (i_sel_valid) begin
            w_prod_n     = i_sel;
            w_sel_seen_n = 1'b1;
          end
          w_idle_cnt_n = 8'd0;
          w_state_n    = S_COLLECT;
        end
      end

      S_COLLECT: begin
        w_reject = i_coin_in && (i_cancel || w_ovf);
        if (w_coin_ok) w_credit_n = w_sum[4:0];
        if (i_sel_valid) begin
          w_prod_n     = i_sel;
          w_sel_seen_n = 1'b1;
        end
        w_idle_cnt_n = w_activity ? 8'd0 : r_idle_cnt + 8'd1;

        if (i_cancel || (r_idle_cnt == L_IDLE_LAST && !w_activity)) begin
          w_idle_cnt_n = 8'd0;
          if (r_credit != 5'd0) begin
            w_state_n = S_REFUND;
          end else begin
            w_state_n    = S_IDLE;
            w_sel_seen_n = 1'b0;
          end
        end else if (r_sel_seen && r_credit >= w_price) begin
          // Sufficiency uses registered values: one cycle of evaluation latency.
          w_idle_cnt_n = 8'd0;
          w_state_n    = S_REQUEST;
        end
      end

      S_REQUEST: begin
        w_reject = i_coin_in;
        if (i_vend_ready) begin
          w_credit_n   = 5'd0;
          w_sel_seen_n = 1'b0;
          w_idle_cnt_n = 8'd0;
          w_state_n    = S_IDLE;
        end
      end

      default: begin
        w_reject     = i_coin_in;
        w_credit_n   = 5'd0;
        w_sel_seen_n = 1'b0;
        w_idle_cnt_n = 8'd0;
        w_state_n    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_credit      <= 5'd0;
      r_prod        <= 2'd0;
      r_sel_seen    <= 1'b0;
      r_idle_cnt    <= 8'd0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_credit      <= w_credit_n;
      r_prod        <= w_prod_n;
      r_sel_seen    <= w_sel_seen_n;
      r_idle_cnt    <= w_idle_cnt_n;
      r_coin_reject <= w_reject;
    end
  end

  assign o_money       = r_credit;
  assign o_product     = r_prod;
  assign o_done        = (r_state == S_REQUEST);
  assign o_refund      = (r_state == S_REFUND);
  assign o_refund_amt  = (r_state == S_REFUND) ? r_credit : 5'd0;
  assign o_coin_reject = r_coin_reject;

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector with a short inactivity timeout.
module tb_coin_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_in = 1'b0;
  logic [1:0] coin_val = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic       vend_ready = 1'b0;
  logic [4:0] money;
  logic [1:0] product;
  logic       done;
  logic       refund;
  logic [4:0] refund_amt;
  logic       coin_reject;

  int n_chk  = 0;
  int n_pass = 0;

  coin_collector #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_coin_in    (coin_in),
    .i_coin_val   (coin_val),
    .i_sel_valid  (sel_valid),
    .i_sel        (sel),
    .i_cancel     (cancel),
    .i_vend_ready (vend_ready),
    .o_money      (money),
    .o_product    (product),
    .o_done       (done),
    .o_refund     (refund),
    .o_refund_amt (refund_amt),
    .o_coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, pass the edge, then drop all strobes.
  task automatic step(input logic c, input logic [1:0] v, input logic sv,
                      input logic [1:0] s, input logic cn, input logic vr);
    coin_in = c; coin_val = v; sel_valid = sv; sel = s; cancel = cn; vend_ready = vr;
    tick();
    coin_in = 1'b0; coin_val = 2'd0; sel_valid = 1'b0; sel = 2'd0;
    cancel = 1'b0; vend_ready = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_money", 32'(money), 0);
    chk("rst_product", 32'(product), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_refund", 32'(refund), 0);
    chk("rst_refund_amt", 32'(refund_amt), 0);
    chk("rst_reject", 32'(coin_reject), 0);
    rst = 1'b0;
    tick();

    // Normal vend: select 15, pay 10 then 5
    step(0, 2'b00, 1, 2'b10, 0, 0);
    chk("vend_sel_product", 32'(product), 2);
    chk("vend_sel_money", 32'(money), 0);
    step(1, 2'b11, 0, 2'b00, 0, 0);
    chk("vend_money10", 32'(money), 10);
    step(1, 2'b10, 0, 2'b00, 0, 0);
    chk("vend_money15", 32'(money), 15);
    chk("vend_done_not_yet", 32'(done), 0);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("vend_done_rise", 32'(done), 1);
    chk("vend_product_held", 32'(product), 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 0, 2'b00, 0, 0);
      chk("vend_hold_done", 32'(done), 1);
      chk("vend_hold_money", 32'(money), 15);
    end
    step(1, 2'b00, 0, 2'b00, 1, 0);
    chk("req_coin_reject", 32'(coin_reject), 1);
    chk("req_cancel_ignored_done", 32'(done), 1);
    chk("req_cancel_no_refund", 32'(refund), 0);
    chk("req_money_stable", 32'(money), 15);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("req_reject_pulse_end", 32'(coin_reject), 0);
    chk("req_done_still", 32'(done), 1);
    step(0, 2'b00, 0, 2'b00, 0, 1);
    chk("vend_ack_done", 32'(done), 0);
    chk("vend_ack_money", 32'(money), 0);

    // Cancel with 5+2+1
    step(1, 2'b10, 0, 2'b00, 0, 0);
    chk("cxl_money5", 32'(money), 5);
    step(1, 2'b01, 0, 2'b00, 0, 0);
    chk("cxl_money7", 32'(money), 7);
    step(1, 2'b00, 0, 2'b00, 0, 0);
    chk("cxl_money8", 32'(money), 8);
    step(0, 2'b00, 0, 2'b00, 1, 0);
    chk("cxl_refund", 32'(refund), 1);
    chk("cxl_refund_amt", 32'(refund_amt), 8);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("cxl_refund_end", 32'(refund), 0);
    chk("cxl_amt_zero", 32'(refund_amt), 0);
    chk("cxl_money0", 32'(money), 0);

    // Overflow: 30 + 2 refused, 30 + 1 accepted
    step(1, 2'b11, 0, 2'b00, 0, 0);
    step(1, 2'b11, 0, 2'b00, 0, 0);
    step(1, 2'b11, 0, 2'b00, 0, 0);
    chk("ovf_money30", 32'(money), 30);
    step(1, 2'b01, 0, 2'b00, 0, 0);
    chk("ovf_reject", 32'(coin_reject), 1);
    chk("ovf_money_kept", 32'(money), 30);
    step(1, 2'b00, 0, 2'b00, 0, 0);
    chk("ovf_accept_reject0", 32'(coin_reject), 0);
    chk("ovf_money31", 32'(money), 31);
    step(0, 2'b00, 0, 2'b00, 1, 0);
    chk("ovf_refund_amt", 32'(refund_amt), 31);
    step(0, 2'b00, 0, 2'b00, 0, 0);

    // Coin and cancel together; coin during REFUND
    step(1, 2'b10, 0, 2'b00, 0, 0);
    chk("sim_money5", 32'(money), 5);
    step(1, 2'b11, 0, 2'b00, 1, 0);
    chk("sim_reject", 32'(coin_reject), 1);
    chk("sim_refund", 32'(refund), 1);
    chk("sim_refund_amt", 32'(refund_amt), 5);
    step(1, 2'b00, 0, 2'b00, 0, 0);
    chk("refund_state_reject", 32'(coin_reject), 1);
    chk("refund_state_end", 32'(refund), 0);
    chk("refund_state_money", 32'(money), 0);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("post_refund_reject0", 32'(coin_reject), 0);
    chk("post_refund_money0", 32'(money), 0);

    // Coin and selection together from IDLE
    step(1, 2'b10, 1, 2'b00, 0, 0);
    chk("both_money", 32'(money), 5);
    chk("both_product", 32'(product), 0);
    chk("both_done0", 32'(done), 0);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("both_done1", 32'(done), 1);
    step(0, 2'b00, 0, 2'b00, 0, 1);
    chk("both_ack_done", 32'(done), 0);
    chk("both_ack_money", 32'(money), 0);

    // Timeout after 4 idle edges
    step(1, 2'b10, 0, 2'b00, 0, 0);
    chk("to_money5", 32'(money), 5);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 0, 2'b00, 0, 0);
      chk("to_wait_no_refund", 32'(refund), 0);
      chk("to_wait_money", 32'(money), 5);
    end
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("to_refund", 32'(refund), 1);
    chk("to_refund_amt", 32'(refund_amt), 5);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("to_refund_end", 32'(refund), 0);
    chk("to_money0", 32'(money), 0);

    // Reset in the middle of REQUEST
    step(1, 2'b11, 1, 2'b01, 0, 0);
    chk("mr_money10", 32'(money), 10);
    chk("mr_product1", 32'(product), 1);
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("mr_done1", 32'(done), 1);
    rst = 1'b1;
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("mr_done0", 32'(done), 0);
    chk("mr_money0", 32'(money), 0);
    chk("mr_product0", 32'(product), 0);
    chk("mr_no_refund", 32'(refund), 0);
    rst = 1'b0;
    step(0, 2'b00, 0, 2'b00, 0, 0);
    chk("mr_after_no_refund", 32'(refund), 0);
    chk("mr_after_done0", 32'(done), 0);

    // vend_ready outside REQUEST is inert
    step(1, 2'b01, 0, 2'b00, 0, 1);
    chk("vr_idle_money2", 32'(money), 2);
    chk("vr_idle_done0", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coin_collector.md
# coin_collector

Front-end credit stage of the vending datapath. It accepts coin strobes and a product selection, and accumulates credit into a 5-bit total. Once credit covers the selected product's price, it presents that total and the product code to the vending unit through a done/vend_ready handshake. It also handles cancel and inactivity refunds, and rejects coins that would overflow the credit register.

## Interface
- TIMEOUT, 255: idle cycles in COLLECT before an automatic refund; legal range 1..255.
- clk  in  1  rising-edge clock; all state updates on this edge.
- rst  in  1  synchronous, active-high reset.
- coin_in  in  1  one-cycle coin strobe.
- coin_val  in  2  coin value: 00=1, 01=2, 10=5, 11=10 units.
- sel_valid  in  1  one-cycle product-selection strobe.
- sel  in  2  product code, sampled when sel_valid=1.
- cancel  in  1  one-cycle cancel request.
- vend_ready  in  1  vending unit has accepted the request.
- money  out  5  current credit; to the vending unit.
- product  out  2  latched product code; to the vending unit.
- done  out  1  request valid; high exactly while in REQUEST.
- refund  out  1  one-cycle refund pulse.
- refund_amt  out  5  refunded amount; valid only while refund=1, otherwise 0.
- coin_reject  out  1  one-cycle pulse when a coin is refused.

## Operation
- Prices: product 00=5, 01=10, 10=15, 11=20.
- Registers: credit (5b), prod (2b), sel_seen (1b), idle_cnt (8b), state.
- States: IDLE, COLLECT, REQUEST, REFUND.
- IDLE: credit=0, sel_seen=0.
  - coin_in or sel_valid: apply it and go to COLLECT.
  - cancel: ignored.
- COLLECT:
  - Accepted coin: credit += value.
  - sel_valid: prod=sel, sel_seen=1. A later selection overwrites an earlier one.
  - Any accepted coin or selection: idle_cnt clears to 0. Otherwise idle_cnt increments.
  - Transitions, highest priority first:
    1. cancel: go to REFUND if credit>0, else to IDLE.
    2. idle_cnt==TIMEOUT-1 with no activity this cycle: same as cancel.
    3. sel_seen and credit>=price(prod), evaluated on registered values: go to REQUEST.
- REQUEST:
  - done=1; money and product held stable.
  - Coins are refused with coin_reject. sel_valid and cancel are ignored.
  - When vend_ready=1 is sampled: credit, sel_seen and idle_cnt clear, and the block goes to IDLE.
- REFUND:
  - Lasts one cycle: refund=1, refund_amt=credit.
  - Next edge: credit, sel_seen and idle_cnt clear, and the block goes to IDLE.
  - Coins are refused with coin_reject.
- Overflow: if credit+value>31 (computed at 6 bits), the coin is refused with coin_reject and credit is unchanged.
- Coin with cancel in the same COLLECT cycle: the coin is refused with coin_reject, and the refund equals the pre-coin credit.
- Coin with sel_valid in the same cycle: both are accepted.
- Credit above price is not clamped. Change computation belongs downstream.
- Reset: all outputs and registers are 0, state is IDLE. Reset mid-REQUEST or mid-REFUND drops the transaction with no refund pulse.

## Timing
- money and product are registered and reflect updates one cycle after the strobe edge.
- Sufficiency is seen at edge N; done rises after edge N+1, giving one cycle of evaluation latency.
- done stays high for every cycle in which vend_ready=0. The handshake completes on the first edge with done=1 and vend_ready=1; done=0 and money=0 after that edge.
- vend_ready=1 outside REQUEST has no effect.
- refund and coin_reject are single-cycle pulses registered from the cycle of the cause, so they appear one cycle later.
- Timeout: with no activity, REFUND is entered on the TIMEOUT-th idle edge after the last activity.

## Test plan
- Reset: hold rst for 2 cycles -> money=0, product=0, done=0, refund=0, coin_reject=0.
- Normal vend: sel=10, then coins 10 and 5 on separate cycles -> money=15, done rises one cycle later. Hold vend_ready=0 for 3 cycles -> done held and money=15 stable. Then vend_ready=1 -> next cycle done=0, money=0.
- Cancel: coins 5, 2, 1 with no selection, then cancel -> refund=1 for one cycle with refund_amt=8, then money=0 in IDLE.
- Overflow: three coins of 10 (credit 30), then a coin of 2 -> coin_reject pulses and money stays 30. A following coin of 1 is accepted -> money=31.
- Simultaneous events: credit 5, then coin 10 and cancel in the same cycle -> coin_reject=1, refund_amt=5. During REQUEST, a coin or a cancel -> coin_reject for the coin, cancel ignored, done held.
- Timeout: TIMEOUT=4, one coin of 5, no further activity -> refund with refund_amt=5 on the 4th idle edge. Mid-REQUEST rst -> done=0, money=0 next cycle, no refund pulse.
